// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered hex display with dead time
// between digits, leading-zero blanking, per-digit enable and per-digit blink.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS       = 8,
    parameter int REFRESH_DIV      = 50000,
    parameter int GHOST_CYCLES     = 16,
    parameter int BLINK_FRAMES     = 64,
    parameter int SEG_ACTIVE_LOW   = 1,
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    lz_blank,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic                    frame_done
);

    localparam int SLOT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0]      DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0]      GHOST_END  = DIV_W'(GHOST_CYCLES);
    localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0]    FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [7:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIGIT_OFF  = (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                            : {NUM_DIGITS{1'b0}};

    // Scan state
    logic [DIV_W-1:0]   div_cnt_reg;
    logic [SLOT_W-1:0]  slot_reg;
    logic [FRAME_W-1:0] frame_cnt_reg;
    logic               blink_phase_reg;
    logic               frame_done_reg;

    // Shadow (written by load) and active (shown) copies of the display data
    logic [4*NUM_DIGITS-1:0] shadow_value_reg;
    logic [NUM_DIGITS-1:0]   shadow_dp_reg;
    logic [NUM_DIGITS-1:0]   shadow_en_reg;
    logic [NUM_DIGITS-1:0]   shadow_blink_reg;
    logic [4*NUM_DIGITS-1:0] active_value_reg;
    logic [NUM_DIGITS-1:0]   active_dp_reg;
    logic [NUM_DIGITS-1:0]   active_en_reg;
    logic [NUM_DIGITS-1:0]   active_blink_reg;

    logic [7:0]            seg_reg;
    logic [NUM_DIGITS-1:0] digit_reg;
    logic [7:0]            seg_next;
    logic [NUM_DIGITS-1:0] digit_next;

    logic [3:0]            nibble [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] zero_from;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [NUM_DIGITS-1:0] slot_sel;

    logic       frame_wrap;
    logic       ghost;
    logic       slot_blank;
    logic [3:0] cur_nibble;
    logic       cur_dp;
    logic       cur_lz;
    logic [7:0] seg_on;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign frame_wrap = (div_cnt_reg == DIV_LAST) && (slot_reg == SLOT_LAST);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            div_cnt_reg     <= '0;
            slot_reg        <= '0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            frame_done_reg <= frame_wrap;
            if (div_cnt_reg == DIV_LAST) begin
                div_cnt_reg <= '0;
                if (slot_reg == SLOT_LAST) begin
                    slot_reg <= '0;
                    if (frame_cnt_reg == FRAME_LAST) begin
                        frame_cnt_reg   <= '0;
                        blink_phase_reg <= ~blink_phase_reg;
                    end else begin
                        frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
                    end
                end else begin
                    slot_reg <= slot_reg + SLOT_W'(1);
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            shadow_value_reg <= '0;
            shadow_dp_reg    <= '0;
            shadow_en_reg    <= '0;
            shadow_blink_reg <= '0;
        end else if (load) begin
            shadow_value_reg <= value_in;
            shadow_dp_reg    <= dp_in;
            shadow_en_reg    <= digit_en;
            shadow_blink_reg <= blink_en;
        end
    end

    // A load on the wrap edge lands in shadow only; active picks it up next frame.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            active_value_reg <= '0;
            active_dp_reg    <= '0;
            active_en_reg    <= '0;
            active_blink_reg <= '0;
        end else if (frame_wrap) begin
            active_value_reg <= shadow_value_reg;
            active_dp_reg    <= shadow_dp_reg;
            active_en_reg    <= shadow_en_reg;
            active_blink_reg <= shadow_blink_reg;
        end
    end

    // zero_from[i]: nibbles i..NUM_DIGITS-1 of the shown value are all zero
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nibble[gi]   = active_value_reg[4*gi +: 4];
            assign slot_sel[gi] = (slot_reg == SLOT_W'(gi));
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign zero_from[gi] = (nibble[gi] == 4'h0);
            end else begin : g_lower
                assign zero_from[gi] = (nibble[gi] == 4'h0) && zero_from[gi+1];
            end
            if (gi == 0) begin : g_lsd
                assign lz_mask[gi] = 1'b0;
            end else begin : g_upper
                assign lz_mask[gi] = lz_blank && zero_from[gi];
            end
        end
    endgenerate

    always_comb begin
        ghost      = (div_cnt_reg < GHOST_END);
        cur_nibble = nibble[slot_reg];
        cur_dp     = active_dp_reg[slot_reg];
        cur_lz     = lz_mask[slot_reg];
        slot_blank = !active_en_reg[slot_reg] || (active_blink_reg[slot_reg] && blink_phase_reg);

        seg_on = {cur_dp, hex_to_seg(cur_nibble)};
        if (slot_blank) begin
            seg_on = 8'h00;
        end else if (cur_lz) begin
            seg_on = {cur_dp, 7'h00};
        end

        if (ghost) begin
            seg_next   = SEG_OFF;
            digit_next = DIGIT_OFF;
        end else begin
            seg_next   = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
            digit_next = (DIGIT_ACTIVE_LOW != 0) ? ~slot_sel : slot_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            seg_reg   <= SEG_OFF;
            digit_reg <= DIGIT_OFF;
        end else begin
            seg_reg   <= seg_next;
            digit_reg <= digit_next;
        end
    end

    assign seg        = seg_reg;
    assign digit      = digit_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues per-frame expected segment
// patterns; a monitor captures each slot's segments and compares at frame_done.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  blink_en = '0;
    logic        lz_blank = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  digit;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // Expected frame: slot i segments in bits [8i+7:8i]
    logic [31:0] exp_q [$];
    int          tag_q [$];
    int          lat_lit_q [$];
    int          lat_fd_q [$];

    logic rst_q = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS(4),
        .REFRESH_DIV(8),
        .GHOST_CYCLES(2),
        .BLINK_FRAMES(2),
        .SEG_ACTIVE_LOW(1),
        .DIGIT_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .load(load),
        .value_in(value_in),
        .dp_in(dp_in),
        .digit_en(digit_en),
        .blink_en(blink_en),
        .lz_blank(lz_blank),
        .seg(seg),
        .digit(digit),
        .frame_done(frame_done)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // rstb as seen by the DUT at each edge
    always @(posedge clk) rst_q <= rstb;

    initial begin : monitor
        logic [7:0] cap [4];
        logic [31:0] e;
        int tag;
        int since_rel;
        bit lit_seen;
        bit fd_seen;
        since_rel = 0;
        lit_seen  = 0;
        fd_seen   = 0;
        for (int i = 0; i < 4; i++) cap[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_q) begin
                check("reset_seg", seg, 8'hFF);
                check("reset_digit", digit, 4'hF);
                since_rel = 0;
                lit_seen  = 0;
                fd_seen   = 0;
                for (int i = 0; i < 4; i++) cap[i] = 8'h00;
            end else begin
                since_rel++;
                if (digit == 4'hF) begin
                    check("ghost_seg", seg, 8'hFF);
                end else begin
                    check("digit_onehot", $countones(~digit), 1);
                    case (digit)
                        4'b1110: cap[0] = seg;
                        4'b1101: cap[1] = seg;
                        4'b1011: cap[2] = seg;
                        4'b0111: cap[3] = seg;
                        default: ;
                    endcase
                    if (!lit_seen) begin
                        lit_seen = 1;
                        check("first_lit_digit", digit, 4'b1110);
                        if (lat_lit_q.size() > 0) begin
                            check("first_lit_latency", since_rel, lat_lit_q.pop_front());
                        end else begin
                            checks++;
                            errors++;
                            $display("FAIL first_lit_latency actual=%0d required=none_queued", since_rel);
                        end
                    end
                end
                if (frame_done) begin
                    if (!fd_seen) begin
                        fd_seen = 1;
                        if (lat_fd_q.size() > 0) begin
                            check("first_frame_done_latency", since_rel, lat_fd_q.pop_front());
                        end else begin
                            checks++;
                            errors++;
                            $display("FAIL first_frame_done_latency actual=%0d required=none_queued", since_rel);
                        end
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected actual=frame_done required=no_frame");
                    end else begin
                        e   = exp_q.pop_front();
                        tag = tag_q.pop_front();
                        for (int i = 0; i < 4; i++) begin
                            check($sformatf("frame%0d_slot%0d_seg", tag, i), cap[i], e[8*i +: 8]);
                            cap[i] = 8'h00;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_done && n < 100);
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout actual=none required=pulse_within_100");
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp,
                           input logic [3:0] en, input logic [3:0] bl);
        value_in = v;
        dp_in    = dp;
        digit_en = en;
        blink_en = bl;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic push(input int tag, input logic [31:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        $display("queued frame %0d expect slot3..0 = %h", tag, e);
    endtask

    initial begin : stimulus
        rstb = 1'b0;
        repeat (3) tick();
        lat_lit_q.push_back(3);
        lat_fd_q.push_back(32);
        push(0, {8'hFF, 8'hFF, 8'hFF, 8'hFF});
        rstb = 1'b1;

        repeat (5) tick();
        do_load(16'h0000, 4'b0000, 4'hF, 4'h0);

        wait_frame();
        push(1, {8'hC0, 8'hC0, 8'hC0, 8'hC0});
        repeat (12) tick();
        do_load(16'h12AF, 4'b0100, 4'hF, 4'h0);

        wait_frame();
        push(2, {8'hF9, 8'h24, 8'h88, 8'h8E});
        repeat (5) tick();
        do_load(16'h0005, 4'b0100, 4'hF, 4'h0);

        wait_frame();
        lz_blank = 1'b1;
        push(3, {8'hFF, 8'h7F, 8'hFF, 8'h92});
        repeat (5) tick();
        do_load(16'h0000, 4'b0000, 4'hF, 4'h0);

        wait_frame();
        push(4, {8'hFF, 8'hFF, 8'hFF, 8'hC0});
        repeat (5) tick();
        do_load(16'h1234, 4'b0000, 4'b1011, 4'b0001);

        wait_frame();
        push(5, {8'hF9, 8'hFF, 8'hB0, 8'h99});
        wait_frame();
        push(6, {8'hF9, 8'hFF, 8'hB0, 8'hFF});
        wait_frame();
        push(7, {8'hF9, 8'hFF, 8'hB0, 8'hFF});
        wait_frame();
        push(8, {8'hF9, 8'hFF, 8'hB0, 8'h99});
        wait_frame();
        push(9, {8'hF9, 8'hFF, 8'hB0, 8'h99});

        // Load sampled on the very edge that ends frame 9
        repeat (31) tick();
        do_load(16'h9876, 4'b0000, 4'hF, 4'h0);
        check("coincident_load_on_boundary", frame_done, 1'b1);
        push(10, {8'hF9, 8'hFF, 8'hB0, 8'hFF});

        wait_frame();
        push(11, {8'h90, 8'h80, 8'hF8, 8'h82});

        // Abort frame 12 at slot 2, div_cnt 5
        wait_frame();
        repeat (21) tick();
        rstb = 1'b0;
        tick();
        tick();
        lat_lit_q.push_back(3);
        lat_fd_q.push_back(32);
        push(0, {8'hFF, 8'hFF, 8'hFF, 8'hFF});
        rstb = 1'b1;

        wait_frame();
        repeat (3) tick();
        check("all_frames_checked", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed 7-segment display controller, the next generation of the board-level 7-segment test driver. It scans NUM_DIGITS common-anode/cathode digits from a hex value, with tear-free double-buffered loading, anti-ghosting dead time, leading-zero blanking, per-digit enable and per-digit blink. It sits under the board top, beside the switch/LED logic, and drives the seg/digit pins directly.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
REFRESH_DIV, 50000, clk cycles per digit slot (>= GHOST_CYCLES+2)
GHOST_CYCLES, 16, cycles at the start of each slot with all digits deselected
BLINK_FRAMES, 64, full frames per blink half-period (>= 1)
SEG_ACTIVE_LOW, 1, 1: seg lines active-low
DIGIT_ACTIVE_LOW, 1, 1: digit selects active-low

Ports:
clk  input  1  system clock
rstb  input  1  reset, synchronous, active-low
load  input  1  one-cycle strobe; captures value_in/dp_in/digit_en/blink_en into shadow
value_in  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) shown on digit i
dp_in  input  NUM_DIGITS  decimal point per digit
digit_en  input  NUM_DIGITS  1 = digit shown, 0 = blanked
blink_en  input  NUM_DIGITS  1 = digit blinks
lz_blank  input  1  leading-zero blanking enable (sampled live)
seg  output  8  seg[7]=dp, seg[6:0]=g..a
digit  output  NUM_DIGITS  one-hot digit select
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (rstb=0 at clk edge): div_cnt=0, slot=0, frame_cnt=0, blink_phase=0, shadow and active registers=0, frame_done=0, seg=all off (8'hFF if SEG_ACTIVE_LOW else 8'h00), digit=all off (all 1s if DIGIT_ACTIVE_LOW else 0). Reset mid-frame aborts the scan; the first slot after release is 0.
- Divider: div_cnt counts 0..REFRESH_DIV-1. At REFRESH_DIV-1: div_cnt->0, slot advances; slot NUM_DIGITS-1 wraps to 0 (frame boundary).
- Frame boundary (same edge as wrap): active <= shadow; frame_done=1 for exactly one cycle; frame_cnt increments; at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- load: shadow <= inputs on the edge where load=1. Active regs never change mid-frame (no tearing). If load and frame boundary coincide, active takes the pre-load shadow; new data appears one frame later. Back-to-back loads: last one wins.
- Leading-zero blank (lz_blank=1): digit i is blanked if all nibbles i..NUM_DIGITS-1 of active value are 0 and i != 0. Digit 0 is never LZ-blanked. dp is still shown on an LZ-blanked digit if set.
- Slot i is blank (seg all off, including dp) if digit_en[i]=0, or blink_en[i]=1 and blink_phase=1. LZ blanking applies after these rules.
- Decode, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. dp=seg[7]. Invert per SEG_ACTIVE_LOW.
- Outputs are registered, with 1-cycle latency from counter state. While div_cnt < GHOST_CYCLES, digit=all off and seg=all off. Otherwise digit selects bit slot only, with polarity per DIGIT_ACTIVE_LOW. Never more than one digit is active.
- Widths: slot is clog2(NUM_DIGITS) bits. div_cnt and frame_cnt are clog2 of their divisor. No overflow states are reachable.

Test Plan:
Bench params: NUM_DIGITS=4, REFRESH_DIV=8, GHOST_CYCLES=2, BLINK_FRAMES=2, both active-low.
1. Reset: hold rstb=0 for 3 cycles, then release. Required: seg=8'hFF, digit=4'hF during reset; first lit digit=4'b1110 appears 3 cycles after release (ghost 2 cycles + 1 reg latency); frame_done first pulses 32 cycles after release.
2. Load: value_in=16'h12AF, dp_in=4'b0100, digit_en=4'hF, blink_en=0, lz_blank=0 mid-frame. Required: old value persists until frame_done. Next frame: slot0 seg=~8'h71, slot1 seg=~8'h77, slot2 seg=~(8'h80|8'h5B), slot3 seg=~8'h06.
3. Leading zeros: value_in=16'h0005, lz_blank=1. Required: slots 3,2,1 seg=8'hFF with digit still one-hot; slot0 seg=~8'h6D. value_in=16'h0000 shows only slot0 '0' (~8'h3F).
4. Blink/enable: blink_en=4'b0001, digit_en=4'b1011. Required: slot2 is always blank; slot0 is lit for 2 frames, then blank for 2 frames, repeating; slots 1 and 3 are steady.
5. Coincident load: assert load on the exact frame-boundary edge with a new value. Required: the following frame shows the previous shadow; the new value appears one frame later.
6. Reset mid-slot: assert rstb=0 at slot2 div_cnt=5. Required: outputs go to all off on the next edge; after release, the scan restarts at slot0 and active value=0 (displays "0000").
